// File: rtl/vid_frame_counter_if.sv
// Tapped AXI4-Stream video handshake: tvalid/tready plus tlast (end of line) and tuser (start of frame).
// The monitor modport observes every signal and drives none of them.
interface vid_frame_counter_if;
    logic tvalid;
    logic tready;
    logic tlast;
    logic tuser;

    modport master  (output tvalid, output tlast, output tuser, input tready);
    modport slave   (input tvalid, input tlast, input tuser, output tready);
    modport monitor (input tvalid, input tready, input tlast, input tuser);
endinterface

// File: rtl/vid_frame_counter.sv
// Passive stream monitor: beat-aligned frame/line/pixel counters, measured line/frame size and lock status.
// Optional macro VDM_STALL_CNT_EN adds stall_cnt, the number of tvalid-without-tready cycles in the last frame.
module vid_frame_counter #(
    parameter  int MAX_HSIZE = 1920,
    parameter  int MAX_VSIZE = 1080,
    localparam int HW        = $clog2(MAX_HSIZE) + 1,
    localparam int VW        = $clog2(MAX_VSIZE) + 1
) (
    input  logic                  aclk,
    input  logic                  reset,
    vid_frame_counter_if.monitor  s_axis,
    output logic [31:0]           frame_cnt,
    output logic [VW-1:0]         line_cnt,
    output logic [HW-1:0]         pixel_cnt,
    output logic                  locked,
    output logic [HW-1:0]         meas_hsize,
    output logic [VW-1:0]         meas_vsize,
    output logic                  meas_valid
`ifdef VDM_STALL_CNT_EN
    ,
    output logic [31:0]           stall_cnt
`endif
);

    typedef enum logic {
        SEEK   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam logic [HW-1:0] PIX_ONE  = HW'(1);
    localparam logic [VW-1:0] LINE_ONE = VW'(1);

    state_t         state;
    state_t         state_next;
    logic           active;

    logic [31:0]    frame_r;
    logic [VW-1:0]  line_r;
    logic [HW-1:0]  pix_r;

    logic           beat;
    logic           sof;
    logic           eol;
    logic           upd;
    logic [HW-1:0]  pix_inc;
    logic [VW-1:0]  line_inc;

    assign beat = s_axis.tvalid & s_axis.tready;
    assign sof  = beat & s_axis.tuser;
    assign eol  = beat & s_axis.tlast;

    // A SOF beat is index (0,0) on its own cycle, before the registers catch up.
    assign pixel_cnt = sof ? '0 : pix_r;
    assign line_cnt  = sof ? '0 : line_r;
    assign frame_cnt = frame_r;

    assign pix_inc  = (pixel_cnt == '1) ? pixel_cnt : pixel_cnt + PIX_ONE;
    assign line_inc = (line_cnt  == '1) ? line_cnt  : line_cnt  + LINE_ONE;

    // Counters advance on beats once locked, or on the SOF that acquires lock.
    assign upd = beat & (active | sof);

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            state <= SEEK;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            SEEK:    if (sof) state_next = ACTIVE;
            ACTIVE:  state_next = ACTIVE;
            default: state_next = SEEK;
        endcase
    end

    always_comb begin
        active = (state == ACTIVE);
        locked = active;
    end

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            frame_r    <= '0;
            line_r     <= '0;
            pix_r      <= '0;
            meas_hsize <= '0;
            meas_vsize <= '0;
            meas_valid <= 1'b0;
        end else if (upd) begin
            if (eol) begin
                pix_r      <= '0;
                line_r     <= line_inc;
                meas_hsize <= pix_inc;
            end else begin
                pix_r <= pix_inc;
                if (sof) begin
                    line_r <= '0;
                end
            end
            if (sof) begin
                frame_r <= frame_r + 32'd1;
                // line_r still holds the number of lines completed in the previous frame.
                if (active) begin
                    meas_vsize <= line_r;
                    meas_valid <= 1'b1;
                end
            end
        end
    end

`ifdef VDM_STALL_CNT_EN
    logic [31:0] stall_acc;
    logic        stall;

    assign stall = active & s_axis.tvalid & ~s_axis.tready;

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            stall_acc <= '0;
            stall_cnt <= '0;
        end else if (sof && active) begin
            stall_cnt <= stall_acc;
            stall_acc <= '0;
        end else if (stall && (stall_acc != '1)) begin
            stall_acc <= stall_acc + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vid_frame_counter.sv
// Directed bench for vid_frame_counter: a default-size instance and a tiny one (MAX_HSIZE=4, MAX_VSIZE=2)
// share one tapped stream so saturation can be exercised in a few beats.
module tb_vid_frame_counter;

    logic aclk;
    logic reset;

    vid_frame_counter_if axis ();

    logic [31:0] frame_cnt;
    logic [11:0] line_cnt;
    logic [11:0] pixel_cnt;
    logic        locked;
    logic [11:0] meas_hsize;
    logic [11:0] meas_vsize;
    logic        meas_valid;

    logic [31:0] s_frame_cnt;
    logic [1:0]  s_line_cnt;
    logic [2:0]  s_pixel_cnt;
    logic        s_locked;
    logic [2:0]  s_meas_hsize;
    logic [1:0]  s_meas_vsize;
    logic        s_meas_valid;

`ifdef VDM_STALL_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] s_stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    vid_frame_counter dut (
        .aclk       (aclk),
        .reset      (reset),
        .s_axis     (axis),
        .frame_cnt  (frame_cnt),
        .line_cnt   (line_cnt),
        .pixel_cnt  (pixel_cnt),
        .locked     (locked),
        .meas_hsize (meas_hsize),
        .meas_vsize (meas_vsize),
        .meas_valid (meas_valid)
`ifdef VDM_STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    vid_frame_counter #(.MAX_HSIZE(4), .MAX_VSIZE(2)) dut_small (
        .aclk       (aclk),
        .reset      (reset),
        .s_axis     (axis),
        .frame_cnt  (s_frame_cnt),
        .line_cnt   (s_line_cnt),
        .pixel_cnt  (s_pixel_cnt),
        .locked     (s_locked),
        .meas_hsize (s_meas_hsize),
        .meas_vsize (s_meas_vsize),
        .meas_valid (s_meas_valid)
`ifdef VDM_STALL_CNT_EN
        ,
        .stall_cnt  (s_stall_cnt)
`endif
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic drive(input logic v, input logic r, input logic l, input logic u);
        @(negedge aclk);
        axis.tvalid = v;
        axis.tready = r;
        axis.tlast  = l;
        axis.tuser  = u;
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge aclk);
        axis.tvalid = 1'b0;
        axis.tready = 1'b0;
        axis.tlast  = 1'b0;
        axis.tuser  = 1'b0;
        reset = 1'b1;
        @(negedge aclk);
        reset = 1'b0;
    endtask

    // Drives an h x v frame starting with SOF; gap inserts a stall between consecutive beats.
    task automatic send_frame(input int h, input int v, input bit gap);
        for (int ln = 0; ln < v; ln++) begin
            for (int p = 0; p < h; p++) begin
                drive(1'b1, 1'b1, p == h - 1, (ln == 0) && (p == 0));
                checks++;
                if (pixel_cnt !== 12'(p) || line_cnt !== 12'(ln)) begin
                    failures++;
                    $display("FAIL frame_beat: pixel_cnt=%0d line_cnt=%0d, expected %0d %0d",
                             pixel_cnt, line_cnt, p, ln);
                end
                if (gap && !((ln == v - 1) && (p == h - 1))) begin
                    drive(1'b1, 1'b0, 1'b0, 1'b0);
                end
            end
        end
    endtask

    task automatic test_reset();
        axis.tvalid = 1'b0;
        axis.tready = 1'b0;
        axis.tlast  = 1'b0;
        axis.tuser  = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge aclk);
        #1;
        checks++;
        if (frame_cnt !== 32'd0 || locked !== 1'b0 || meas_hsize !== 12'd0 ||
            meas_vsize !== 12'd0 || meas_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: frame=%0d locked=%0b hs=%0d vs=%0d mv=%0b, expected all 0",
                     frame_cnt, locked, meas_hsize, meas_vsize, meas_valid);
        end
        @(negedge aclk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, i == 2, 1'b0);
            checks++;
            if (locked !== 1'b0 || frame_cnt !== 32'd0 || line_cnt !== 12'd0 || pixel_cnt !== 12'd0) begin
                failures++;
                $display("FAIL seek_ignore: locked=%0b frame=%0d line=%0d pix=%0d, expected 0 0 0 0",
                         locked, frame_cnt, line_cnt, pixel_cnt);
            end
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (locked !== 1'b0 || pixel_cnt !== 12'd0 || line_cnt !== 12'd0) begin
            failures++;
            $display("FAIL seek_after: locked=%0b pix=%0d line=%0d, expected 0 0 0",
                     locked, pixel_cnt, line_cnt);
        end
    endtask

    task automatic test_frames(input bit gap);
        pulse_reset();
        send_frame(4, 3, gap);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (frame_cnt !== 32'd1 || meas_hsize !== 12'd4 || meas_valid !== 1'b0 ||
            line_cnt !== 12'd3 || locked !== 1'b1) begin
            failures++;
            $display("FAIL frame1_end gap=%0b: frame=%0d hs=%0d mv=%0b line=%0d locked=%0b, expected 1 4 0 3 1",
                     gap, frame_cnt, meas_hsize, meas_valid, line_cnt, locked);
        end
        send_frame(4, 3, gap);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (frame_cnt !== 32'd2 || meas_hsize !== 12'd4 || meas_vsize !== 12'd3 || meas_valid !== 1'b1) begin
            failures++;
            $display("FAIL frame2_end gap=%0b: frame=%0d hs=%0d vs=%0d mv=%0b, expected 2 4 3 1",
                     gap, frame_cnt, meas_hsize, meas_vsize, meas_valid);
        end
`ifdef VDM_STALL_CNT_EN
        checks++;
        if (stall_cnt !== (gap ? 32'd11 : 32'd0)) begin
            failures++;
            $display("FAIL stall_cnt gap=%0b: got %0d, expected %0d", gap, stall_cnt, gap ? 11 : 0);
        end
`endif
    endtask

    task automatic test_one_pixel_line();
        pulse_reset();
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        checks++;
        if (pixel_cnt !== 12'd1 || line_cnt !== 12'd0) begin
            failures++;
            $display("FAIL two_beat_line: pix=%0d line=%0d, expected 1 0", pixel_cnt, line_cnt);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (meas_hsize !== 12'd2 || line_cnt !== 12'd1 || pixel_cnt !== 12'd0) begin
            failures++;
            $display("FAIL two_beat_meas: hs=%0d line=%0d pix=%0d, expected 2 1 0",
                     meas_hsize, line_cnt, pixel_cnt);
        end
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        checks++;
        if (pixel_cnt !== 12'd0 || line_cnt !== 12'd0) begin
            failures++;
            $display("FAIL sof_eol_beat: pix=%0d line=%0d, expected 0 0", pixel_cnt, line_cnt);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (line_cnt !== 12'd1 || pixel_cnt !== 12'd0 || meas_hsize !== 12'd1 ||
            meas_vsize !== 12'd1 || meas_valid !== 1'b1 || frame_cnt !== 32'd2) begin
            failures++;
            $display("FAIL sof_eol_after: line=%0d pix=%0d hs=%0d vs=%0d mv=%0b frame=%0d, expected 1 0 1 1 1 2",
                     line_cnt, pixel_cnt, meas_hsize, meas_vsize, meas_valid, frame_cnt);
        end
    endtask

    task automatic test_pixel_saturation();
        pulse_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b1, 1'b0, i == 0);
            checks++;
            if (s_pixel_cnt !== 3'((i > 7) ? 7 : i) || pixel_cnt !== 12'(i)) begin
                failures++;
                $display("FAIL pix_sat_beat %0d: small=%0d big=%0d, expected %0d %0d",
                         i, s_pixel_cnt, pixel_cnt, (i > 7) ? 7 : i, i);
            end
        end
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        checks++;
        if (s_pixel_cnt !== 3'd7 || pixel_cnt !== 12'd10) begin
            failures++;
            $display("FAIL pix_sat_eol_beat: small=%0d big=%0d, expected 7 10", s_pixel_cnt, pixel_cnt);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (s_meas_hsize !== 3'd7 || s_pixel_cnt !== 3'd0 || s_line_cnt !== 2'd1 ||
            meas_hsize !== 12'd11 || line_cnt !== 12'd1) begin
            failures++;
            $display("FAIL pix_sat_meas: s_hs=%0d s_pix=%0d s_line=%0d hs=%0d line=%0d, expected 7 0 1 11 1",
                     s_meas_hsize, s_pixel_cnt, s_line_cnt, meas_hsize, line_cnt);
        end
    endtask

    task automatic test_line_saturation();
        pulse_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 1'b1, i == 0);
            checks++;
            if (s_line_cnt !== 2'((i > 3) ? 3 : i) || line_cnt !== 12'(i)) begin
                failures++;
                $display("FAIL line_sat_beat %0d: small=%0d big=%0d, expected %0d %0d",
                         i, s_line_cnt, line_cnt, (i > 3) ? 3 : i, i);
            end
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (s_line_cnt !== 2'd3 || line_cnt !== 12'd5 || s_meas_hsize !== 3'd1) begin
            failures++;
            $display("FAIL line_sat_end: small=%0d big=%0d s_hs=%0d, expected 3 5 1",
                     s_line_cnt, line_cnt, s_meas_hsize);
        end
    endtask

    task automatic test_reset_mid_frame();
        pulse_reset();
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (pixel_cnt !== 12'd2 || line_cnt !== 12'd1 || locked !== 1'b1 || frame_cnt !== 32'd1) begin
            failures++;
            $display("FAIL mid_frame_pos: pix=%0d line=%0d locked=%0b frame=%0d, expected 2 1 1 1",
                     pixel_cnt, line_cnt, locked, frame_cnt);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (pixel_cnt !== 12'd0 || line_cnt !== 12'd0 || locked !== 1'b0 ||
            frame_cnt !== 32'd0 || meas_hsize !== 12'd0) begin
            failures++;
            $display("FAIL async_reset: pix=%0d line=%0d locked=%0b frame=%0d hs=%0d, expected all 0",
                     pixel_cnt, line_cnt, locked, frame_cnt, meas_hsize);
        end
        @(negedge aclk);
        reset = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (locked !== 1'b0 || pixel_cnt !== 12'd0 || line_cnt !== 12'd0 || meas_hsize !== 12'd0) begin
            failures++;
            $display("FAIL post_reset_seek: locked=%0b pix=%0d line=%0d hs=%0d, expected 0 0 0 0",
                     locked, pixel_cnt, line_cnt, meas_hsize);
        end
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (locked !== 1'b1 || frame_cnt !== 32'd1 || pixel_cnt !== 12'd1 || meas_valid !== 1'b0) begin
            failures++;
            $display("FAIL relock: locked=%0b frame=%0d pix=%0d mv=%0b, expected 1 1 1 0",
                     locked, frame_cnt, pixel_cnt, meas_valid);
        end
    endtask

    initial begin
        test_reset();
        test_frames(1'b0);
        test_frames(1'b1);
        test_one_pixel_line();
        test_pixel_saturation();
        test_line_saturation();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
